// File: rtl/word_align_pkg.sv
// Shared types and sizing helpers for the word-alignment controller.
package word_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/word_align_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module word_align_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/word_align_ctrl.sv
// Word-boundary alignment initiator: slips the divider until the training
// pattern is seen MATCH_CNT times in a row, or gives up after MAX_SLIPS.
module word_align_ctrl
  import word_align_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] PATTERN   = 8'h5C,
  parameter int unsigned       MATCH_CNT = 16,
  parameter int unsigned       PULSE_W   = 2,
  parameter int unsigned       SLIP_WAIT = 8,
  parameter int unsigned       MAX_SLIPS = 16,
  parameter int unsigned       LOSS_CNT  = 4
) (
  input  logic                             CLKI,
  input  logic                             RST,
  input  logic                             START,
  input  logic [DATA_W-1:0]                DATAIN,
  output logic                             ALIGNWD,
  output logic                             LOCKED,
  output logic                             FAIL,
  output logic                             BUSY,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   SLIP_CNT
);

  localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
  localparam int unsigned MW = cnt_w(MATCH_CNT);
  localparam int unsigned LW = cnt_w(LOSS_CNT);
  localparam int unsigned TW = cnt_w(max2(PULSE_W, SLIP_WAIT));

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_CNT - 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] PULSE_LD   = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] WAIT_LD    = TW'(SLIP_WAIT - 1);

  state_t          state_q;
  logic [MW-1:0]   match_cnt_q;
  logic [LW-1:0]   loss_cnt_q;
  logic [SW-1:0]   slip_cnt_q;
  logic            alignwd_q;
  logic            locked_q;
  logic            fail_q;
  logic            busy_q;

  logic            word_ok;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;

  assign word_ok = (DATAIN == PATTERN);

  // Timer is loaded on the same edge that enters SLIP or WAIT, so the load
  // decision is taken from the current state rather than a registered copy.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state_q)
      ST_CHECK: begin
        if (!word_ok && (slip_cnt_q != SLIP_MAX)) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_SLIP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = WAIT_LD;
        end
      end
      default: ;
    endcase
  end

  word_align_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (CLKI),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      loss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      alignwd_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q     <= ST_CHECK;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (word_ok) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_q     <= ST_LOCKED;
              match_cnt_q <= '0;
              loss_cnt_q  <= '0;
              locked_q    <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              match_cnt_q <= match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_q <= '0;
            if (slip_cnt_q == SLIP_MAX) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= ST_SLIP;
              slip_cnt_q <= slip_cnt_q + 1'b1;
              alignwd_q  <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          if (tmr_done) begin
            state_q   <= ST_WAIT;
            alignwd_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (tmr_done) begin
            state_q     <= ST_CHECK;
            match_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (START || (!word_ok && (loss_cnt_q == LOSS_LAST))) begin
            state_q     <= ST_CHECK;
            match_cnt_q <= '0;
            loss_cnt_q  <= '0;
            slip_cnt_q  <= '0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
          end else if (!word_ok) begin
            loss_cnt_q <= loss_cnt_q + 1'b1;
          end else begin
            loss_cnt_q <= '0;
          end
        end
        ST_FAIL: begin
          if (START) begin
            state_q     <= ST_CHECK;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ALIGNWD  = alignwd_q;
  assign LOCKED   = locked_q;
  assign FAIL     = fail_q;
  assign BUSY     = busy_q;
  assign SLIP_CNT = slip_cnt_q;

endmodule

// File: tb/tb_word_align_ctrl.sv
// Bench for word_align_ctrl: rotating-divider model, behavioural reference, directed and random stimulus.
module tb_word_align_ctrl;

  localparam logic [7:0] PAT  = 8'h5C;
  localparam int         MC   = 16;
  localparam int         PW   = 2;
  localparam int         SWT  = 8;
  localparam int         MS   = 16;
  localparam int         LC   = 4;

  localparam int M_IDLE = 0, M_CHECK = 1, M_SLIP = 2, M_WAIT = 3, M_LOCK = 4, M_FAIL = 5;

  logic       CLKI = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] DATAIN;
  logic       ALIGNWD, LOCKED, FAIL, BUSY;
  logic [4:0] SLIP_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  word_align_ctrl #(
    .DATA_W    (8),
    .PATTERN   (PAT),
    .MATCH_CNT (MC),
    .PULSE_W   (PW),
    .SLIP_WAIT (SWT),
    .MAX_SLIPS (MS),
    .LOSS_CNT  (LC)
  ) dut (
    .CLKI     (CLKI),
    .RST      (RST),
    .START    (START),
    .DATAIN   (DATAIN),
    .ALIGNWD  (ALIGNWD),
    .LOCKED   (LOCKED),
    .FAIL     (FAIL),
    .BUSY     (BUSY),
    .SLIP_CNT (SLIP_CNT)
  );

  always #5 CLKI = ~CLKI;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Divider model: word rotates by one bit on every ALIGNWD rising edge.
  int         req_off = 0, req_seq = 0, seen_seq = 0;
  int         off = 0;
  bit         force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic       aw_d = 1'b0;

  always @(negedge CLKI) begin
    #1;
    if (req_seq != seen_seq) begin
      seen_seq = req_seq;
      off = req_off;
    end
    if (ALIGNWD === 1'b1 && aw_d !== 1'b1) off = (off + 1) % 8;
    aw_d = ALIGNWD;
    DATAIN = force_en ? force_val : rotl(PAT, off);
  end

  task automatic set_off(input int o);
    req_off = o;
    req_seq++;
  endtask

  // Pulse-shape monitor
  int rises = 0, hi_len = 0, lo_len = 0, hi_min = 1000, hi_max = 0, gap_min = 1000;
  bit seen_fall = 1'b0;
  int clr_req = 0, clr_seen = 0;

  always @(negedge CLKI) begin
    #2;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rises = 0; hi_len = 0; lo_len = 0;
      hi_min = 1000; hi_max = 0; gap_min = 1000; seen_fall = 1'b0;
    end
    if (ALIGNWD === 1'b1) begin
      if (hi_len == 0) begin
        rises++;
        if (seen_fall && lo_len < gap_min) gap_min = lo_len;
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (hi_len > 0) begin
        if (hi_len < hi_min) hi_min = hi_len;
        if (hi_len > hi_max) hi_max = hi_len;
        seen_fall = 1'b1;
        hi_len = 0;
      end
      lo_len++;
    end
  end

  // Reference model: mode plus elapsed-cycle bookkeeping, checked every cycle.
  int m_mode = M_IDLE, m_run = 0, m_slips = 0, m_bad = 0, m_el = 0;

  always @(posedge CLKI) begin
    bit r, s, hit;
    r   = (RST === 1'b1);
    s   = (START === 1'b1);
    hit = (DATAIN === PAT);
    if (r) begin
      m_mode = M_IDLE; m_run = 0; m_slips = 0; m_bad = 0; m_el = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_CHECK; m_run = 0; m_slips = 0; end
        M_CHECK: begin
          if (hit) begin
            m_run++;
            if (m_run == MC) begin m_mode = M_LOCK; m_bad = 0; end
          end else begin
            m_run = 0;
            if (m_slips == MS) m_mode = M_FAIL;
            else begin m_slips++; m_mode = M_SLIP; m_el = 0; end
          end
        end
        M_SLIP: begin
          m_el++;
          if (m_el == PW) begin m_mode = M_WAIT; m_el = 0; end
        end
        M_WAIT: begin
          m_el++;
          if (m_el == SWT) begin m_mode = M_CHECK; m_run = 0; end
        end
        M_LOCK: begin
          if (s) begin m_mode = M_CHECK; m_run = 0; m_slips = 0; end
          else if (!hit) begin
            m_bad++;
            if (m_bad == LC) begin m_mode = M_CHECK; m_run = 0; m_slips = 0; end
          end else m_bad = 0;
        end
        default: if (s) begin m_mode = M_CHECK; m_run = 0; m_slips = 0; end
      endcase
    end
    #1;
    chk("m_alignwd", ALIGNWD, m_mode == M_SLIP);
    chk("m_locked", LOCKED, m_mode == M_LOCK);
    chk("m_fail", FAIL, m_mode == M_FAIL);
    chk("m_busy", BUSY, m_mode == M_CHECK || m_mode == M_SLIP || m_mode == M_WAIT);
    chk("m_slip_cnt", SLIP_CNT, m_slips);
  end

  task automatic wait_locked(input string name, input int bound);
    int k;
    k = 0;
    while (LOCKED !== 1'b1 && k < bound) begin
      @(negedge CLKI);
      k++;
    end
    chk(name, LOCKED, 1);
  endtask

  initial begin
    int k;
    RST = 1'b1; START = 1'b0; DATAIN = PAT;
    repeat (3) @(negedge CLKI);
    chk("rst_alignwd", ALIGNWD, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_fail", FAIL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_slip_cnt", SLIP_CNT, 0);
    RST = 1'b0;
    @(negedge CLKI);

    // 1: aligned from the start
    set_off(0); clr_req++; START = 1'b1; k = 0;
    do begin
      @(negedge CLKI); START = 1'b0; k++;
    end while (LOCKED !== 1'b1 && k < 100);
    chk("t1_lock_latency", k - 1, 16);
    chk("t1_rises", rises, 0);
    chk("t1_slip_cnt", SLIP_CNT, 0);

    // 2: offset 5 needs three slips
    set_off(5); clr_req++; START = 1'b1; k = 0;
    do begin
      @(negedge CLKI); START = 1'b0; k++;
    end while (LOCKED !== 1'b1 && k < 300);
    chk("t2_locked", LOCKED, 1);
    chk("t2_rises", rises, 3);
    chk("t2_hi_min", hi_min, 2);
    chk("t2_hi_max", hi_max, 2);
    chk("t2_gap_ge9", gap_min >= 9, 1);
    chk("t2_slip_cnt", SLIP_CNT, 3);

    // 3: never matches -> FAIL after 16 slips
    force_en = 1'b1; force_val = 8'h00; clr_req++; START = 1'b1; k = 0;
    do begin
      @(negedge CLKI); START = 1'b0; k++;
    end while (FAIL !== 1'b1 && k < 500);
    chk("t3_fail", FAIL, 1);
    chk("t3_rises", rises, 16);
    chk("t3_busy", BUSY, 0);
    chk("t3_slip_cnt", SLIP_CNT, 16);
    force_en = 1'b0; set_off(0); START = 1'b1;
    @(negedge CLKI); START = 1'b0;
    chk("t3_fail_cleared", FAIL, 0);
    chk("t3_busy_restart", BUSY, 1);

    // 4: loss-of-lock tolerance
    wait_locked("t4_lock", 100);
    force_en = 1'b1; force_val = 8'hFF;
    repeat (3) @(negedge CLKI);
    force_en = 1'b0;
    @(negedge CLKI);
    chk("t4_hold_after_3bad", LOCKED, 1);
    force_en = 1'b1;
    repeat (3) @(negedge CLKI);
    chk("t4_hold_at_3bad", LOCKED, 1);
    @(negedge CLKI);
    force_en = 1'b0;
    chk("t4_drop_locked", LOCKED, 0);
    chk("t4_drop_busy", BUSY, 1);
    chk("t4_drop_slip_cnt", SLIP_CNT, 0);
    wait_locked("t4_relock", 100);

    // 5: reset mid-pulse, START alongside RST ignored
    set_off(3); START = 1'b1; k = 0;
    do begin
      @(negedge CLKI); START = 1'b0; k++;
    end while (ALIGNWD !== 1'b1 && k < 30);
    chk("t5_in_slip", ALIGNWD, 1);
    RST = 1'b1; START = 1'b1;
    @(negedge CLKI);
    chk("t5_alignwd", ALIGNWD, 0);
    chk("t5_locked", LOCKED, 0);
    chk("t5_fail", FAIL, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_slip_cnt", SLIP_CNT, 0);
    RST = 1'b0; START = 1'b0;
    repeat (2) @(negedge CLKI);
    chk("t5_stay_idle", BUSY, 0);

    // 6: bad word at the 16th compare after 15 matches
    set_off(0); START = 1'b1;
    @(negedge CLKI); START = 1'b0;
    repeat (15) @(negedge CLKI);
    chk("t6_no_lock_15", LOCKED, 0);
    force_en = 1'b1; force_val = 8'hFF;
    @(negedge CLKI);
    force_en = 1'b0;
    chk("t6_slip", ALIGNWD, 1);
    chk("t6_not_locked", LOCKED, 0);
    chk("t6_slip_cnt1", SLIP_CNT, 1);
    wait_locked("t6_lock", 400);
    chk("t6_slip_cnt8", SLIP_CNT, 8);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge CLKI);
      START = ($urandom_range(0, 39) == 0);
      RST   = ($urandom_range(0, 199) == 0);
      if (START && $urandom_range(0, 1) == 0) set_off($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        force_en  = ($urandom_range(0, 2) == 0);
        force_val = 8'($urandom);
      end
    end
    RST = 1'b0; START = 1'b0; force_en = 1'b0;
    repeat (2) @(negedge CLKI);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
